if_stage: RTL and testbench

- Instruction-fetch stage of the pipelined MIPS core.
- Holds the architectural PC and drives the instruction-memory word address.
- Supplies PC+4 to the next-PC calculator and accepts its NPC back.
- Registers the fetched instruction, PC and PC+4 into the IF/ID pipeline register for decode.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/pc_reg.sv | 23 ++
 rtl/if_stage.sv | 76 +++++++
 tb/tb_if_stage.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the pipelined MIPS core
package cpu_pkg;

   localparam int          WORD_W       = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
   localparam int          IM_AW_DEF    = 10;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with synchronous reset and load enable
module pc_reg
   import cpu_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_VAL = RESET_PC_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] q
);

   // Reset to the fetch base; otherwise load the next PC unless frozen
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RESET_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage and IF/ID register (optional fetch check: IF_PC_CHECK_EN)
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter int                IM_AW    = IM_AW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] npc,
   input  logic              stall,
   input  logic              flush,
   input  logic [WORD_W-1:0] instr_F,
   output logic [WORD_W-1:0] pc_F,
   output logic [WORD_W-1:0] pc_plus_4_F,
   output logic [IM_AW-1:0]  im_addr,
   output logic [WORD_W-1:0] instr_D,
   output logic [WORD_W-1:0] pc_D,
   output logic [WORD_W-1:0] pc_plus_4_D,
   output logic              valid_D,
   output logic              exc_D,
   output logic [WORD_W-1:0] fetch_cnt
);

   logic [WORD_W-1:0] pc_offset;
   logic              fetch_fault;

   pc_reg #(
      .RESET_VAL (RESET_PC)
   ) u_pc_reg (
      .clk   (clk),
      .reset (reset),
      .en    (!stall),
      .d     (npc),
      .q     (pc_F)
   );

   assign pc_plus_4_F = pc_F + 32'd4;

   // Offset from the memory base; a PC below the base wraps to a huge offset,
   // which the range check below treats as out of memory.
   assign pc_offset = pc_F - RESET_PC;
   assign im_addr   = IM_AW'(pc_offset >> 2);

`ifdef IF_PC_CHECK_EN
   assign fetch_fault = (pc_F[1:0] != 2'b00) || ((pc_offset >> (IM_AW + 2)) != '0);
`else
   assign fetch_fault = 1'b0;
`endif

   // IF/ID register: reset > flush > stall > normal capture
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_D     <= NOP_INSTR;
         pc_D        <= '0;
         pc_plus_4_D <= '0;
         valid_D     <= 1'b0;
         exc_D       <= 1'b0;
         fetch_cnt   <= '0;
      end else if (flush) begin
         instr_D     <= NOP_INSTR;
         pc_D        <= '0;
         pc_plus_4_D <= '0;
         valid_D     <= 1'b0;
         exc_D       <= 1'b0;
      end else if (!stall) begin
         instr_D     <= fetch_fault ? NOP_INSTR : instr_F;
         pc_D        <= pc_F;
         pc_plus_4_D <= pc_plus_4_F;
         valid_D     <= 1'b1;
         exc_D       <= fetch_fault;
         fetch_cnt   <= fetch_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed table-driven bench for if_stage (honours IF_PC_CHECK_EN)
module tb_if_stage;

`ifdef IF_PC_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] npc;
   logic        stall;
   logic        flush;
   logic [31:0] instr_F;
   logic [31:0] pc_F;
   logic [31:0] pc_plus_4_F;
   logic [9:0]  im_addr;
   logic [31:0] instr_D;
   logic [31:0] pc_D;
   logic [31:0] pc_plus_4_D;
   logic        valid_D;
   logic        exc_D;
   logic [31:0] fetch_cnt;

   logic        use_ovr;
   logic [31:0] ovr_instr;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Instruction memory model: word k holds 0x1000_0000 + k unless overridden
   assign instr_F = use_ovr ? ovr_instr : (32'h1000_0000 + {22'b0, im_addr});

   if_stage dut (
      .clk         (clk),
      .reset       (reset),
      .npc         (npc),
      .stall       (stall),
      .flush       (flush),
      .instr_F     (instr_F),
      .pc_F        (pc_F),
      .pc_plus_4_F (pc_plus_4_F),
      .im_addr     (im_addr),
      .instr_D     (instr_D),
      .pc_D        (pc_D),
      .pc_plus_4_D (pc_plus_4_D),
      .valid_D     (valid_D),
      .exc_D       (exc_D),
      .fetch_cnt   (fetch_cnt)
   );

   typedef struct {
      bit          rst;
      bit          stl;
      bit          fls;
      bit          ovr;
      logic [31:0] oi;
      logic [31:0] npc;
      logic [31:0] pc;
      logic [31:0] p4;
      logic [31:0] im;
      logic [31:0] instr;
      logic [31:0] instr_chk;
      bit          exc_chk;
      logic [31:0] pcd;
      logic [31:0] p4d;
      bit          vld;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      //          rst stl fls ovr oi            npc           pc            p4            im      instr         instr_chk     exc pcd           p4d           vld cnt
      vecs[0]  = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h3000,     32'h3004,     32'h0,  32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 32'd0};
      vecs[1]  = '{0, 0, 0, 0, 32'h0,        32'h3004,     32'h3004,     32'h3008,     32'h1,  32'h10000000, 32'h10000000, 0, 32'h3000,     32'h3004,     1, 32'd1};
      vecs[2]  = '{0, 0, 0, 0, 32'h0,        32'h3008,     32'h3008,     32'h300C,     32'h2,  32'h10000001, 32'h10000001, 0, 32'h3004,     32'h3008,     1, 32'd2};
      vecs[3]  = '{0, 1, 0, 0, 32'h0,        32'h300C,     32'h3008,     32'h300C,     32'h2,  32'h10000001, 32'h10000001, 0, 32'h3004,     32'h3008,     1, 32'd2};
      vecs[4]  = '{0, 1, 0, 0, 32'h0,        32'h300C,     32'h3008,     32'h300C,     32'h2,  32'h10000001, 32'h10000001, 0, 32'h3004,     32'h3008,     1, 32'd2};
      vecs[5]  = '{0, 0, 0, 0, 32'h0,        32'h300C,     32'h300C,     32'h3010,     32'h3,  32'h10000002, 32'h10000002, 0, 32'h3008,     32'h300C,     1, 32'd3};
      vecs[6]  = '{0, 1, 0, 0, 32'h0,        32'h3010,     32'h300C,     32'h3010,     32'h3,  32'h10000002, 32'h10000002, 0, 32'h3008,     32'h300C,     1, 32'd3};
      vecs[7]  = '{1, 1, 1, 0, 32'h0,        32'h3010,     32'h3000,     32'h3004,     32'h0,  32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 32'd0};
      vecs[8]  = '{0, 0, 0, 1, 32'h10220002, 32'h300C,     32'h300C,     32'h3010,     32'h3,  32'h10220002, 32'h10220002, 0, 32'h3000,     32'h3004,     1, 32'd1};
      vecs[9]  = '{0, 0, 0, 1, 32'h08000C04, 32'h3010,     32'h3010,     32'h3014,     32'h4,  32'h08000C04, 32'h08000C04, 0, 32'h300C,     32'h3010,     1, 32'd2};
      vecs[10] = '{0, 1, 1, 0, 32'h0,        32'h3020,     32'h3010,     32'h3014,     32'h4,  32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 32'd2};
      vecs[11] = '{0, 0, 1, 0, 32'h0,        32'h3014,     32'h3014,     32'h3018,     32'h5,  32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 32'd2};
      vecs[12] = '{0, 0, 0, 0, 32'h0,        32'h3FFC,     32'h3FFC,     32'h4000,     32'h3FF,32'h10000005, 32'h10000005, 0, 32'h3014,     32'h3018,     1, 32'd3};
      vecs[13] = '{0, 0, 0, 0, 32'h0,        32'h4000,     32'h4000,     32'h4004,     32'h0,  32'h100003FF, 32'h100003FF, 0, 32'h3FFC,     32'h4000,     1, 32'd4};
      vecs[14] = '{0, 0, 0, 0, 32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h3FF,32'h10000000, 32'h0,        1, 32'h4000,     32'h4004,     1, 32'd5};
      vecs[15] = '{0, 0, 0, 0, 32'h0,        32'h3002,     32'h3002,     32'h3006,     32'h0,  32'h100003FF, 32'h0,        1, 32'hFFFFFFFC, 32'h0,        1, 32'd6};
      vecs[16] = '{0, 0, 0, 0, 32'h0,        32'h3008,     32'h3008,     32'h300C,     32'h2,  32'h10000000, 32'h0,        1, 32'h3002,     32'h3006,     1, 32'd7};
      vecs[17] = '{0, 0, 0, 0, 32'h0,        32'h300C,     32'h300C,     32'h3010,     32'h3,  32'h10000002, 32'h10000002, 0, 32'h3008,     32'h300C,     1, 32'd8};

      reset = 1'b1; stall = 1'b0; flush = 1'b0; npc = 32'h0; use_ovr = 1'b0; ovr_instr = 32'h0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 18; i++) begin
         reset     = vecs[i].rst;
         stall     = vecs[i].stl;
         flush     = vecs[i].fls;
         use_ovr   = vecs[i].ovr;
         ovr_instr = vecs[i].oi;
         npc       = vecs[i].npc;
         @(posedge clk);
         #1;
         check($sformatf("v%0d pc_F", i),        pc_F,               vecs[i].pc);
         check($sformatf("v%0d pc_plus_4_F", i), pc_plus_4_F,        vecs[i].p4);
         check($sformatf("v%0d im_addr", i),     {22'b0, im_addr},   vecs[i].im);
         check($sformatf("v%0d instr_D", i),     instr_D,            CHK ? vecs[i].instr_chk : vecs[i].instr);
         check($sformatf("v%0d pc_D", i),        pc_D,               vecs[i].pcd);
         check($sformatf("v%0d pc_plus_4_D", i), pc_plus_4_D,        vecs[i].p4d);
         check($sformatf("v%0d valid_D", i),     {31'b0, valid_D},   {31'b0, vecs[i].vld});
         check($sformatf("v%0d exc_D", i),       {31'b0, exc_D},     {31'b0, CHK & vecs[i].exc_chk});
         check($sformatf("v%0d fetch_cnt", i),   fetch_cnt,          vecs[i].cnt);
      end

      // Reset held across two stalled cycles, then the first fetch must come from the base
      use_ovr = 1'b0;
      reset = 1'b1; stall = 1'b1; flush = 1'b0; npc = 32'h5000;
      repeat (2) @(posedge clk);
      #1;
      check("hs reset pc_F", pc_F, 32'h3000);
      check("hs reset fetch_cnt", fetch_cnt, 32'd0);
      reset = 1'b0; stall = 1'b0; npc = 32'h3004;
      @(posedge clk);
      #1;
      check("hs first pc_D", pc_D, 32'h3000);
      check("hs first instr_D", instr_D, 32'h1000_0000);
      check("hs first pc_F", pc_F, 32'h3004);
      check("hs first fetch_cnt", fetch_cnt, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
